// File: rtl/ysyx_23060251_axi_pkg.sv
// Shared AXI4-Lite types for the SRAM slave: response codes,
// bus widths, one-hot FSM encodings and the address decode helper.
package ysyx_23060251_axi_pkg;

  localparam int AXI_AW = 32;
  localparam int AXI_DW = 32;
  localparam int AXI_SW = AXI_DW / 8;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [2:0] {
    R_IDLE = 3'b001,
    R_WAIT = 3'b010,
    R_RESP = 3'b100
  } rd_state_e;

  typedef enum logic [2:0] {
    W_IDLE = 3'b001,
    W_WAIT = 3'b010,
    W_RESP = 3'b100
  } wr_state_e;

  // Word-granular hit test; comparing the word offset avoids
  // overflowing base + 4*depth near the top of the address map.
  function automatic logic addr_hit(
    input logic [AXI_AW-1:0] addr,
    input logic [AXI_AW-1:0] base,
    input int unsigned       depth
  );
    logic [AXI_AW-1:0] off;
    off = addr - base;
    return (addr >= base) && ({2'b00, off[AXI_AW-1:2]} < depth);
  endfunction

endpackage

// File: rtl/ysyx_23060251_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4), loads seed on reset.
// Ports: clk_i, rst_i (sync, active-high), seed[7:0], q[7:0].
`ifdef YSYX_23060251_SRAM_RAND_DELAY_EN
module ysyx_23060251_lfsr8 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  logic [7:0] q_q, q_d;

  always_comb begin
    q_d = {q_q[6:0], q_q[7] ^ q_q[5] ^ q_q[4] ^ q_q[3]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) q_q <= seed;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule
`endif

// File: rtl/axi_sram_slv.sv
// AXI4-Lite word-array slave with independent read/write FSMs.
// Ports: clk_i, rst_i (sync, active-high), AR/R, AW/W/B channels.
// Macro YSYX_23060251_SRAM_RAND_DELAY_EN: LFSR-driven wait counts.
module axi_sram_slv
  import ysyx_23060251_axi_pkg::*;
#(
  parameter int unsigned DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned READ_LAT  = 2,
  parameter int unsigned WRITE_LAT = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ar_valid_i,
  input  logic [31:0] ar_addr_i,
  output logic        ar_ready_o,
  output logic        r_valid_o,
  output logic [31:0] r_data_o,
  output axi_resp_t   r_resp_o,
  input  logic        r_ready_i,
  input  logic        aw_valid_i,
  input  logic [31:0] aw_addr_i,
  output logic        aw_ready_o,
  input  logic        w_valid_i,
  input  logic [31:0] w_data_i,
  input  logic [3:0]  w_strb_i,
  output logic        w_ready_o,
  output logic        b_valid_o,
  output axi_resp_t   b_resp_o,
  input  logic        b_ready_i
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0] mem_q [DEPTH];

  // Number of wait cycles for the transaction being accepted now.
  logic [CNT_W-1:0] rd_wait, wr_wait;

`ifdef YSYX_23060251_SRAM_RAND_DELAY_EN
  logic [7:0] rd_lfsr, wr_lfsr;
  logic       unused_lfsr;

  ysyx_23060251_lfsr8 u_rd_lfsr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .seed  (8'hA5),
    .q     (rd_lfsr)
  );

  ysyx_23060251_lfsr8 u_wr_lfsr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .seed  (8'h5A),
    .q     (wr_lfsr)
  );

  assign rd_wait     = {4'b0000, rd_lfsr[3:0]};
  assign wr_wait     = {4'b0000, wr_lfsr[3:0]};
  assign unused_lfsr = ^{rd_lfsr[7:4], wr_lfsr[7:4]};
`else
  assign rd_wait = CNT_W'(READ_LAT);
  assign wr_wait = CNT_W'(WRITE_LAT);
`endif

  // ---------------- read path ----------------
  rd_state_e        r_state_q, r_state_d;
  logic [CNT_W-1:0] r_cnt_q, r_cnt_d;
  logic [31:0]      r_addr_q, r_addr_d;
  logic [31:0]      r_data_q, r_data_d;
  axi_resp_t        r_resp_q, r_resp_d;
  logic [31:0]      rd_addr;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_hit;
  logic             rd_sample;

  // Zero-latency reads sample straight from the AR bus.
  assign rd_addr = (r_state_q == R_IDLE) ? ar_addr_i : r_addr_q;
  assign rd_hit  = addr_hit(rd_addr, BASE_ADDR, DEPTH);
  assign rd_idx  = IDX_W'((rd_addr - BASE_ADDR) >> 2);

  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    r_addr_d  = r_addr_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;
    rd_sample = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (ar_valid_i) begin
          r_addr_d = ar_addr_i;
          if (rd_wait == '0) begin
            r_state_d = R_RESP;
            rd_sample = 1'b1;
          end else begin
            r_cnt_d   = rd_wait - 1'b1;
            r_state_d = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (r_cnt_q == '0) begin
          r_state_d = R_RESP;
          rd_sample = 1'b1;
        end else begin
          r_cnt_d = r_cnt_q - 1'b1;
        end
      end
      R_RESP: begin
        if (r_ready_i) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
    if (rd_sample) begin
      r_data_d = rd_hit ? mem_q[rd_idx] : '0;
      r_resp_d = rd_hit ? OKAY : DECERR;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= '0;
      r_addr_q  <= '0;
      r_data_q  <= '0;
      r_resp_q  <= OKAY;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      r_addr_q  <= r_addr_d;
      r_data_q  <= r_data_d;
      r_resp_q  <= r_resp_d;
    end
  end

  assign ar_ready_o = (r_state_q == R_IDLE);
  assign r_valid_o  = (r_state_q == R_RESP);
  assign r_data_o   = r_data_q;
  assign r_resp_o   = r_resp_q;

  // ---------------- write path ----------------
  wr_state_e        w_state_q, w_state_d;
  logic [CNT_W-1:0] w_cnt_q, w_cnt_d;
  logic             aw_got_q, aw_got_d;
  logic             w_got_q, w_got_d;
  logic [31:0]      aw_addr_q, aw_addr_d;
  logic [31:0]      w_data_q, w_data_d;
  logic [3:0]       w_strb_q, w_strb_d;
  axi_resp_t        b_resp_q, b_resp_d;
  logic [31:0]      wr_addr, wr_data;
  logic [3:0]       wr_strb;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_hit;
  logic             wr_commit;

  // A channel not yet captured contributes its live bus value,
  // which covers same-cycle capture with zero write latency.
  assign wr_addr = aw_got_q ? aw_addr_q : aw_addr_i;
  assign wr_data = w_got_q ? w_data_q : w_data_i;
  assign wr_strb = w_got_q ? w_strb_q : w_strb_i;
  assign wr_hit  = addr_hit(wr_addr, BASE_ADDR, DEPTH);
  assign wr_idx  = IDX_W'((wr_addr - BASE_ADDR) >> 2);

  always_comb begin
    w_state_d = w_state_q;
    w_cnt_d   = w_cnt_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    aw_addr_d = aw_addr_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    b_resp_d  = b_resp_q;
    wr_commit = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_valid_i && !aw_got_q) begin
          aw_got_d  = 1'b1;
          aw_addr_d = aw_addr_i;
        end
        if (w_valid_i && !w_got_q) begin
          w_got_d  = 1'b1;
          w_data_d = w_data_i;
          w_strb_d = w_strb_i;
        end
        if (aw_got_d && w_got_d) begin
          if (wr_wait == '0) begin
            w_state_d = W_RESP;
            wr_commit = 1'b1;
          end else begin
            w_cnt_d   = wr_wait - 1'b1;
            w_state_d = W_WAIT;
          end
        end
      end
      W_WAIT: begin
        if (w_cnt_q == '0) begin
          w_state_d = W_RESP;
          wr_commit = 1'b1;
        end else begin
          w_cnt_d = w_cnt_q - 1'b1;
        end
      end
      W_RESP: begin
        if (b_ready_i) begin
          w_state_d = W_IDLE;
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
        end
      end
      default: begin
        w_state_d = W_IDLE;
        aw_got_d  = 1'b0;
        w_got_d   = 1'b0;
      end
    endcase
    if (wr_commit) b_resp_d = wr_hit ? OKAY : DECERR;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state_q <= W_IDLE;
      w_cnt_q   <= '0;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_resp_q  <= OKAY;
    end else begin
      w_state_q <= w_state_d;
      w_cnt_q   <= w_cnt_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      aw_addr_q <= aw_addr_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      b_resp_q  <= b_resp_d;
    end
  end

  // Array is not reset; a commit racing reset is dropped.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_commit && wr_hit) begin
      for (int i = 0; i < AXI_SW; i++) begin
        if (wr_strb[i]) mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign aw_ready_o = (w_state_q == W_IDLE) && !aw_got_q;
  assign w_ready_o  = (w_state_q == W_IDLE) && !w_got_q;
  assign b_valid_o  = (w_state_q == W_RESP);
  assign b_resp_o   = b_resp_q;

endmodule
